axi_wr_arbiter_2to1: RTL and testbench

- Arbitrates two AXI write masters (s0, s1) onto one downstream AXI write port (m), e.g. the slave side of a write FIFO.
- AW: round-robin with a grant lock. W: routed in AW-grant order via an internal order FIFO. B: routed back by an ID bit appended on the master side.
- Sits in front of the write-path FIFO so that two requesters share one write channel.

---
 rtl/axi_wr_arbiter_2to1_if.sv | 76 +++++++
 rtl/axi_wr_arbiter_2to1.sv | 232 +++++++++++++++++++++++
 tb/tb_axi_wr_arbiter_2to1.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_arbiter_2to1_if.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter_2to1_if
//
// Purpose:
//   Bundles one AXI write port (AW, W and B channels) so that the arbiter and
//   its users connect one interface per port instead of ~25 loose wires.
//   The same interface describes the two upstream ports and the downstream
//   port. The downstream port is instantiated with ID_WIDTH one larger,
//   because it carries the extra source bit.
//
// Parameters:
//   DATA_WIDTH  write data width
//   ADDR_WIDTH  address width
//   STRB_WIDTH  write strobe width
//   ID_WIDTH    AWID / WID / BID width on this port
//
// Signals:
//   AW : awid, awaddr, awlen, awsize, awburst, awlock, awqos, awvalid, awready
//   W  : wid, wdata, wstrb, wlast, wvalid, wready
//   B  : bid, bresp, bvalid, bready
//
// Modports:
//   master  side that issues write requests (drives AW/W, accepts B)
//   slave   side that receives write requests (drives AW/W ready, issues B)
// ---------------------------------------------------------------------------
interface axi_wr_arbiter_2to1_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8
);

   // Write address channel
   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awlock;
   logic [3:0]            awqos;
   logic                  awvalid;
   logic                  awready;

   // Write data channel
   logic [ID_WIDTH-1:0]   wid;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   // Write response channel
   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awqos, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awqos, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/axi_wr_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter_2to1
//
// Purpose:
//   Lets two AXI write masters share one downstream write port, for example
//   the slave side of a write-path FIFO.
//   - AW: round-robin arbitration. Once the downstream port has seen
//     awvalid, the grant is locked until the handshake completes, so the
//     payload stays stable.
//   - W : bursts are forwarded in the order their AW was accepted. A small
//     order FIFO holds the source index of every accepted AW whose W burst
//     is not yet complete. Burst ends are detected by wlast only.
//   - B : the source index is the top bit of the downstream ID, so responses
//     route back combinationally, in any order.
//
// Parameters:
//   DATA_WIDTH   write data width
//   ADDR_WIDTH   address width
//   STRB_WIDTH   write strobe width
//   ID_WIDTH     upstream ID width (downstream ID is ID_WIDTH+1)
//   ORDER_DEPTH  order FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk    rising-edge clock for all logic
//   rst_n  synchronous active-low reset
//   s0     upstream port 0 (slave modport, ID_WIDTH wide IDs)
//   s1     upstream port 1 (slave modport, ID_WIDTH wide IDs)
//   m      downstream port (master modport, ID_WIDTH+1 wide IDs, {src, id})
// ---------------------------------------------------------------------------
module axi_wr_arbiter_2to1 #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int STRB_WIDTH  = DATA_WIDTH / 8,
   parameter int ID_WIDTH    = 8,
   parameter int ORDER_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   axi_wr_arbiter_2to1_if.slave   s0,
   axi_wr_arbiter_2to1_if.slave   s1,
   axi_wr_arbiter_2to1_if.master  m
);

   // One extra pointer bit tells a full FIFO apart from an empty one when
   // the index bits are equal.
   localparam int PTR_WIDTH = $clog2(ORDER_DEPTH) + 1;

   typedef enum logic {
      AW_IDLE   = 1'b0,
      AW_LOCKED = 1'b1
   } aw_state_t;

   // AW arbitration state
   aw_state_t             aw_state;
   aw_state_t             aw_state_next;
   logic                  rr_favour_s1;
   logic                  grant_q;
   logic                  aw_grant;
   logic                  aw_active;
   logic                  aw_valid_sel;
   logic                  aw_push;

   // Order FIFO of source indices, in AW acceptance order
   logic                  order_mem [ORDER_DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr;
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  w_head;
   logic                  w_pop;

   // Selected upstream payloads
   logic [ID_WIDTH-1:0]   aw_id_sel;
   logic [ADDR_WIDTH-1:0] aw_addr_sel;
   logic [ID_WIDTH-1:0]   w_id_sel;
   logic [DATA_WIDTH-1:0] w_data_sel;
   logic [STRB_WIDTH-1:0] w_strb_sel;
   logic                  w_last_sel;
   logic                  w_valid_sel;
   logic                  b_sel;

   // FIFO status comes only from the registered pointers. A pop in the
   // same cycle therefore cannot free a slot for a push in that cycle. AW
   // picks up again on the cycle after the pop.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_WIDTH-1] != rd_ptr[PTR_WIDTH-1]) &&
                       (wr_ptr[PTR_WIDTH-2:0] == rd_ptr[PTR_WIDTH-2:0]);
   assign w_head     = order_mem[rd_ptr[PTR_WIDTH-2:0]];

   // AW state register, round-robin pointer and held grant. After the
   // downstream port accepts a burst, the pointer favours the other master.
   // The grant is re-captured every cycle. In LOCKED, the combinational
   // grant simply echoes grant_q, so the captured value stays frozen.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aw_state     <= AW_IDLE;
         rr_favour_s1 <= 1'b0;
         grant_q      <= 1'b0;
      end else begin
         aw_state <= aw_state_next;
         grant_q  <= aw_grant;
         if (aw_push) begin
            rr_favour_s1 <= !aw_grant;
         end
      end
   end

   // AW arbitration and next-state logic.
   // In IDLE, a request is granted only while the order FIFO has room. When
   // both masters request, the round-robin pointer decides. In LOCKED, the
   // earlier grant holds, even if the other master starts requesting,
   // until the downstream handshake completes.
   always_comb begin
      aw_state_next = aw_state;
      aw_grant      = grant_q;
      aw_active     = 1'b0;
      case (aw_state)
         AW_IDLE: begin
            if (!fifo_full && (s0.awvalid || s1.awvalid)) begin
               aw_active = 1'b1;
               if (s0.awvalid && s1.awvalid) begin
                  aw_grant = rr_favour_s1;
               end else begin
                  aw_grant = s1.awvalid;
               end
            end
         end
         AW_LOCKED: begin
            aw_active = !fifo_full;
         end
         default: begin
            aw_active = 1'b0;
         end
      endcase

      aw_valid_sel = aw_active && (aw_grant ? s1.awvalid : s0.awvalid);
      aw_push      = aw_valid_sel && m.awready;

      case (aw_state)
         AW_IDLE: begin
            if (aw_valid_sel && !m.awready) begin
               aw_state_next = AW_LOCKED;
            end
         end
         AW_LOCKED: begin
            if (aw_push) begin
               aw_state_next = AW_IDLE;
            end
         end
         default: begin
            aw_state_next = AW_IDLE;
         end
      endcase
   end

   // AW payload mux. The downstream ID gets the source index as its top bit.
   // The B channel uses that bit to route the response back.
   assign aw_id_sel   = aw_grant ? s1.awid   : s0.awid;
   assign aw_addr_sel = aw_grant ? s1.awaddr : s0.awaddr;

   assign m.awid    = {aw_grant, aw_id_sel};
   assign m.awaddr  = aw_addr_sel;
   assign m.awlen   = aw_grant ? s1.awlen   : s0.awlen;
   assign m.awsize  = aw_grant ? s1.awsize  : s0.awsize;
   assign m.awburst = aw_grant ? s1.awburst : s0.awburst;
   assign m.awlock  = aw_grant ? s1.awlock  : s0.awlock;
   assign m.awqos   = aw_grant ? s1.awqos   : s0.awqos;
   assign m.awvalid = aw_valid_sel;

   // awready goes only to the granted master, and only while it is actually
   // being presented downstream. The ungranted master never sees awready.
   assign s0.awready = aw_valid_sel && !aw_grant && m.awready;
   assign s1.awready = aw_valid_sel &&  aw_grant && m.awready;

   // Order FIFO pointers. A push and a pop in the same cycle both take
   // effect, so occupancy stays the same. The pointers wrap naturally at
   // PTR_WIDTH bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (aw_push) begin
            wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         end
         if (w_pop) begin
            rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         end
      end
   end

   // Order FIFO storage. It needs no reset: emptiness is decided by the
   // pointers alone.
   always_ff @(posedge clk) begin
      if (rst_n && aw_push) begin
         order_mem[wr_ptr[PTR_WIDTH-2:0]] <= aw_grant;
      end
   end

   // W routing. The source at the FIFO head owns the W channel until it
   // sends wlast. With an empty FIFO, nothing passes, so W offered before or
   // in the same cycle as its AW waits a cycle.
   assign w_id_sel    = w_head ? s1.wid    : s0.wid;
   assign w_data_sel  = w_head ? s1.wdata  : s0.wdata;
   assign w_strb_sel  = w_head ? s1.wstrb  : s0.wstrb;
   assign w_last_sel  = w_head ? s1.wlast  : s0.wlast;
   assign w_valid_sel = !fifo_empty && (w_head ? s1.wvalid : s0.wvalid);

   assign m.wid    = {w_head, w_id_sel};
   assign m.wdata  = w_data_sel;
   assign m.wstrb  = w_strb_sel;
   assign m.wlast  = w_last_sel;
   assign m.wvalid = w_valid_sel;

   assign s0.wready = !fifo_empty && !w_head && m.wready;
   assign s1.wready = !fifo_empty &&  w_head && m.wready;

   assign w_pop = w_valid_sel && m.wready && w_last_sel;

   // B routing. This path is purely combinational and independent of the
   // AW/W state, so responses may come back in any order.
   assign b_sel = m.bid[ID_WIDTH];

   assign s0.bid    = m.bid[ID_WIDTH-1:0];
   assign s1.bid    = m.bid[ID_WIDTH-1:0];
   assign s0.bresp  = m.bresp;
   assign s1.bresp  = m.bresp;
   assign s0.bvalid = m.bvalid && !b_sel;
   assign s1.bvalid = m.bvalid &&  b_sel;
   assign m.bready  = b_sel ? s1.bready : s0.bready;

endmodule

// File: tb/tb_axi_wr_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_arbiter_2to1
//
// Randomised traffic from two write masters into the arbiter, checked
// against a transaction-level reference model:
//   - a queue of source indices in grant order decides which source owns W,
//   - a round-robin favour bit and a held grant decide which AW wins,
//   - B routing is checked directly from the top ID bit.
// Reset behaviour is checked at start-up and again in the middle of traffic.
// ---------------------------------------------------------------------------
module tb_axi_wr_arbiter_2to1;

   localparam int DATA_WIDTH  = 32;
   localparam int ADDR_WIDTH  = 32;
   localparam int STRB_WIDTH  = DATA_WIDTH / 8;
   localparam int ID_WIDTH    = 8;
   localparam int ORDER_DEPTH = 4;

   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [DATA_WIDTH-1:0] data;
      logic [STRB_WIDTH-1:0] strb;
      logic                  last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   axi_wr_arbiter_2to1_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .STRB_WIDTH(STRB_WIDTH), .ID_WIDTH(ID_WIDTH)) s0_axi ();
   axi_wr_arbiter_2to1_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .STRB_WIDTH(STRB_WIDTH), .ID_WIDTH(ID_WIDTH)) s1_axi ();
   axi_wr_arbiter_2to1_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .STRB_WIDTH(STRB_WIDTH), .ID_WIDTH(ID_WIDTH + 1)) m_axi ();

   axi_wr_arbiter_2to1 #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH),
      .ID_WIDTH(ID_WIDTH), .ORDER_DEPTH(ORDER_DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .s0(s0_axi),
      .s1(s1_axi),
      .m(m_axi)
   );

   // Upstream master models
   logic                  aw_valid [2];
   logic [ID_WIDTH-1:0]   aw_id    [2];
   logic [ADDR_WIDTH-1:0] aw_addr  [2];
   logic [7:0]            aw_len   [2];
   logic [2:0]            aw_size  [2];
   logic [1:0]            aw_burst [2];
   logic                  aw_lock  [2];
   logic [3:0]            aw_qos   [2];
   logic                  w_valid  [2];
   beat_t                 w_cur    [2];
   logic                  b_ready  [2];
   beat_t                 w_q0 [$];
   beat_t                 w_q1 [$];

   // Downstream slave stimulus
   logic                  m_awready;
   logic                  m_wready;
   logic                  m_bvalid;
   logic [ID_WIDTH:0]     m_bid;
   logic [1:0]            m_bresp;

   // Reference model: grant order, round-robin favour, held grant
   bit                    order_q [$];
   bit                    favour;
   bit                    locked;
   bit                    locked_src;

   int                    tests = 0;
   int                    fails = 0;

   // Counts one comparison and reports it if the observed value differs
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Copies the master/slave model state onto the interface wires
   task automatic driveBus();
      s0_axi.awvalid = aw_valid[0]; s0_axi.awid = aw_id[0]; s0_axi.awaddr = aw_addr[0];
      s0_axi.awlen = aw_len[0]; s0_axi.awsize = aw_size[0]; s0_axi.awburst = aw_burst[0];
      s0_axi.awlock = aw_lock[0]; s0_axi.awqos = aw_qos[0];
      s0_axi.wvalid = w_valid[0]; s0_axi.wid = w_cur[0].id; s0_axi.wdata = w_cur[0].data;
      s0_axi.wstrb = w_cur[0].strb; s0_axi.wlast = w_cur[0].last; s0_axi.bready = b_ready[0];
      s1_axi.awvalid = aw_valid[1]; s1_axi.awid = aw_id[1]; s1_axi.awaddr = aw_addr[1];
      s1_axi.awlen = aw_len[1]; s1_axi.awsize = aw_size[1]; s1_axi.awburst = aw_burst[1];
      s1_axi.awlock = aw_lock[1]; s1_axi.awqos = aw_qos[1];
      s1_axi.wvalid = w_valid[1]; s1_axi.wid = w_cur[1].id; s1_axi.wdata = w_cur[1].data;
      s1_axi.wstrb = w_cur[1].strb; s1_axi.wlast = w_cur[1].last; s1_axi.bready = b_ready[1];
      m_axi.awready = m_awready; m_axi.wready = m_wready;
      m_axi.bvalid = m_bvalid; m_axi.bid = m_bid; m_axi.bresp = m_bresp;
   endtask

   task automatic clearState();
      for (int n = 0; n < 2; n++) begin
         aw_valid[n] = 1'b0; aw_id[n] = '0; aw_addr[n] = '0; aw_len[n] = '0;
         aw_size[n] = '0; aw_burst[n] = '0; aw_lock[n] = 1'b0; aw_qos[n] = '0;
         w_valid[n] = 1'b0; w_cur[n] = '0; b_ready[n] = 1'b0;
      end
      w_q0.delete();
      w_q1.delete();
      order_q.delete();
      favour = 1'b0;
      locked = 1'b0;
      locked_src = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
   endtask

   // Starts a new burst on master n and queues its W beats
   task automatic newBurst(input int n);
      beat_t b;
      aw_valid[n] = 1'b1;
      aw_id[n]    = ID_WIDTH'($urandom);
      aw_addr[n]  = ADDR_WIDTH'($urandom);
      aw_len[n]   = 8'($urandom_range(3));
      aw_size[n]  = 3'($urandom);
      aw_burst[n] = 2'($urandom);
      aw_lock[n]  = 1'($urandom);
      aw_qos[n]   = 4'($urandom);
      for (int i = 0; i <= int'(aw_len[n]); i++) begin
         b.id   = aw_id[n];
         b.data = DATA_WIDTH'($urandom);
         b.strb = STRB_WIDTH'($urandom);
         b.last = (i == int'(aw_len[n]));
         if (n == 0) w_q0.push_back(b);
         else        w_q1.push_back(b);
      end
   endtask

   task automatic loadBeat(input int n);
      if ($urandom_range(99) < 80) begin
         if (n == 0 && w_q0.size() > 0) begin
            w_cur[0] = w_q0.pop_front();
            w_valid[0] = 1'b1;
         end else if (n == 1 && w_q1.size() > 0) begin
            w_cur[1] = w_q1.pop_front();
            w_valid[1] = 1'b1;
         end
      end
   endtask

   // One cycle of random stimulus. Valids are held until their handshake.
   task automatic applyStimulus(input int unsigned aw_rate, input int unsigned awr_rate,
                                input int unsigned wr_rate);
      for (int n = 0; n < 2; n++) begin
         if (!aw_valid[n] && $urandom_range(99) < aw_rate) newBurst(n);
         if (!w_valid[n]) loadBeat(n);
         b_ready[n] = 1'($urandom);
      end
      m_awready = ($urandom_range(99) < awr_rate);
      m_wready  = ($urandom_range(99) < wr_rate);
      m_bvalid  = 1'($urandom);
      m_bid     = (ID_WIDTH + 1)'($urandom);
      m_bresp   = 2'($urandom);
      driveBus();
   endtask

   // Compares the DUT against the model for the current cycle, then advances
   // the model and the master models to the state after the next edge.
   task automatic modelCheck();
      bit   full, src, exp_awvalid, h, exp_wvalid, sel;
      logic got_awr [2];
      logic got_wr  [2];
      got_awr[0] = s0_axi.awready; got_awr[1] = s1_axi.awready;
      got_wr[0]  = s0_axi.wready;  got_wr[1]  = s1_axi.wready;

      full = (order_q.size() == ORDER_DEPTH);
      if (locked)                        src = locked_src;
      else if (aw_valid[0] && aw_valid[1]) src = favour;
      else                               src = aw_valid[1];
      exp_awvalid = !full && aw_valid[src];

      checkOutput("aw_valid", 64'(m_axi.awvalid), 64'(exp_awvalid));
      checkOutput("aw_ready", 64'({got_awr[1], got_awr[0]}),
                  64'({exp_awvalid && m_awready && src, exp_awvalid && m_awready && !src}));
      if (exp_awvalid) begin
         checkOutput("aw_payload",
            64'({m_axi.awid, m_axi.awlen, m_axi.awaddr, m_axi.awsize, m_axi.awburst,
                 m_axi.awlock, m_axi.awqos}),
            64'({src, aw_id[src], aw_len[src], aw_addr[src], aw_size[src], aw_burst[src],
                 aw_lock[src], aw_qos[src]}));
      end

      h = 1'b0;
      exp_wvalid = 1'b0;
      if (order_q.size() == 0) begin
         checkOutput("w_idle", 64'({m_axi.wvalid, got_wr[1], got_wr[0]}), 64'(0));
      end else begin
         h = order_q[0];
         exp_wvalid = w_valid[h];
         checkOutput("w_route", 64'({m_axi.wvalid, got_wr[1], got_wr[0]}),
                     64'({exp_wvalid, h && m_wready, !h && m_wready}));
         if (exp_wvalid) begin
            checkOutput("w_payload",
               64'({m_axi.wid, m_axi.wlast, m_axi.wstrb, m_axi.wdata}),
               64'({h, w_cur[h].id, w_cur[h].last, w_cur[h].strb, w_cur[h].data}));
         end
      end

      sel = m_bid[ID_WIDTH];
      checkOutput("b_valid", 64'({s1_axi.bvalid, s0_axi.bvalid}),
                  64'({m_bvalid && sel, m_bvalid && !sel}));
      checkOutput("b_ready", 64'(m_axi.bready), 64'(b_ready[sel]));
      if (m_bvalid) begin
         checkOutput("b_payload",
            64'(sel ? {s1_axi.bid, s1_axi.bresp} : {s0_axi.bid, s0_axi.bresp}),
            64'({m_bid[ID_WIDTH-1:0], m_bresp}));
      end

      if (exp_wvalid && m_wready && w_cur[h].last) void'(order_q.pop_front());
      if (exp_awvalid && m_awready) begin
         order_q.push_back(src);
         favour = !src;
         locked = 1'b0;
      end else if (exp_awvalid) begin
         locked = 1'b1;
         locked_src = src;
      end
      for (int n = 0; n < 2; n++) begin
         if (aw_valid[n] && got_awr[n]) aw_valid[n] = 1'b0;
         if (w_valid[n] && got_wr[n])   w_valid[n] = 1'b0;
      end
   endtask

   task automatic runPhase(input int cycles, input int unsigned aw_rate,
                           input int unsigned awr_rate, input int unsigned wr_rate);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         applyStimulus(aw_rate, awr_rate, wr_rate);
         @(negedge clk);
         modelCheck();
      end
   endtask

   // Resets the DUT, whatever traffic is in flight, and checks the cycle
   // after reset: no valid/ready is raised even though both downstream
   // readies and both upstream wvalids are high. The first grant then goes
   // to s0.
   task automatic resetCheck();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      clearState();
      m_awready = 1'b1;
      m_wready  = 1'b1;
      w_valid[0] = 1'b1;
      w_valid[1] = 1'b1;
      w_cur[0].last = 1'b1;
      w_cur[1].last = 1'b1;
      driveBus();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_outputs",
         64'({m_axi.awvalid, m_axi.wvalid, m_axi.bready, s0_axi.awready, s0_axi.wready,
              s0_axi.bvalid, s1_axi.awready, s1_axi.wready, s1_axi.bvalid}), 64'(0));
      @(posedge clk);
      #1;
      clearState();
      aw_valid[0] = 1'b1; aw_id[0] = 8'h12;
      aw_valid[1] = 1'b1; aw_id[1] = 8'h34;
      driveBus();
      @(negedge clk);
      checkOutput("rst_rr_s0", 64'({m_axi.awvalid, m_axi.awid}), 64'({1'b1, 9'h012}));
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      clearState();
      driveBus();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      clearState();
      driveBus();
      resetCheck();
      runPhase(600, 50, 70, 70);
      runPhase(400, 100, 100, 90);
      runPhase(400, 100, 40, 10);
      resetCheck();
      runPhase(400, 70, 60, 60);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
